// File: rtl/au_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : au_result_queue
// Description : In-order result FIFO behind the 32-bit arithmetic unit.
//               Captures AU results with a valid/ready handshake, presents
//               them to writeback, and commits the architectural HI/LO pair
//               when a MULT/DIV result leaves the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module au_result_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [W-1:0]             in_s,
  input  logic [W-1:0]             in_hi,
  input  logic [W-1:0]             in_lo,
  input  logic                     in_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_op,
  output logic [W-1:0]             out_data,
  output logic                     out_zero,
  output logic [W-1:0]             hi_q,
  output logic [W-1:0]             lo_q,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] C_EMPTY = '0;

  // Entry storage; contents need no reset since occupancy gates visibility.
  logic [1:0]   r_mem_op   [DEPTH];
  logic [W-1:0] r_mem_data [DEPTH];
  logic [W-1:0] r_mem_hi   [DEPTH];
  logic [W-1:0] r_mem_lo   [DEPTH];
  logic         r_mem_zero [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;

  logic          w_push;
  logic          w_pop;
  logic [W-1:0]  w_data;
  logic          w_zero;

  // Handshake qualifiers; ready is a pure function of occupancy so a pop
  // while full never opens a same-cycle push.
  always_comb begin
    in_ready  = !rst_n && (r_count != C_FULL);
    out_valid = (r_count != C_EMPTY);
    full      = (r_count == C_FULL);
    w_push    = in_valid && in_ready;
    w_pop     = out_valid && out_ready;
  end

  // Select what writeback sees: lo half for MULT/DIV, s for ADD/SUB, and
  // derive the zero flag from the full 2W-bit result for MULT/DIV.
  always_comb begin
    w_data = in_op[1] ? in_lo : in_s;
    w_zero = in_op[1] ? ((in_hi == '0) && (in_lo == '0)) : in_zero;
  end

  // Write the incoming result into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr]   <= in_op;
      r_mem_data[r_wr_ptr] <= w_data;
      r_mem_hi[r_wr_ptr]   <= in_hi;
      r_mem_lo[r_wr_ptr]   <= in_lo;
      r_mem_zero[r_wr_ptr] <= w_zero;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Architectural HI/LO commit only as MULT/DIV results are popped, which
  // keeps them in program order with respect to writeback.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_pop && r_mem_op[r_rd_ptr][1]) begin
      r_hi <= r_mem_hi[r_rd_ptr];
      r_lo <= r_mem_lo[r_rd_ptr];
    end
  end

  // Head-of-queue outputs read asynchronously from the read slot.
  always_comb begin
    out_op   = r_mem_op[r_rd_ptr];
    out_data = r_mem_data[r_rd_ptr];
    out_zero = r_mem_zero[r_rd_ptr];
    hi_q     = r_hi;
    lo_q     = r_lo;
    count    = r_count;
  end

endmodule
`default_nettype wire

// File: tb/tb_au_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_au_result_queue
// Description : Directed self-checking bench for au_result_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_au_result_queue;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_s;
  logic [W-1:0]  in_hi;
  logic [W-1:0]  in_lo;
  logic          in_zero;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_op;
  logic [W-1:0]  out_data;
  logic          out_zero;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;
  logic [2:0]    count;
  logic          full;

  int n_checks = 0;
  int n_errors = 0;

  au_result_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_s      (in_s),
    .in_hi     (in_hi),
    .in_lo     (in_lo),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .hi_q      (hi_q),
    .lo_q      (lo_q),
    .count     (count),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [31:0] s,
                        input logic [31:0] hi, input logic [31:0] lo, input logic z);
    in_valid = v;
    in_op    = op;
    in_s     = s;
    in_hi    = hi;
    in_lo    = lo;
    in_zero  = z;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    out_ready = 1'b0;
    set_in(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    step();

    // Reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_hi", hi_q, 32'h0);
    check("rst_lo", lo_q, 32'h0);
    rst_n = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Single ADD push, no bypass
    set_in(1'b1, 2'b00, 32'h00000005, 32'hDEAD0000, 32'h0000BEEF, 1'b0);
    #1;
    check("t1_no_bypass", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", out_data, 32'h00000005);
    check("t1_op", 32'(out_op), 32'd0);
    check("t1_count", 32'(count), 32'd1);
    check("t1_hi", hi_q, 32'h0);
    check("t1_lo", lo_q, 32'h0);
    pop_one();
    check("t1_count_after_pop", 32'(count), 32'd0);
    check("t1_hi_add_pop", hi_q, 32'h0);

    // MULT: lo on data, computed zero ignores in_zero, commit at pop
    set_in(1'b1, 2'b10, 32'h00001234, 32'h00000001, 32'h80000000, 1'b1);
    step();
    in_valid = 1'b0;
    check("t2_data", out_data, 32'h80000000);
    check("t2_zero", 32'(out_zero), 32'd0);
    check("t2_op", 32'(out_op), 32'd2);
    check("t2_hi_before", hi_q, 32'h0);
    check("t2_lo_before", lo_q, 32'h0);
    pop_one();
    check("t2_hi_after", hi_q, 32'h00000001);
    check("t2_lo_after", lo_q, 32'h80000000);
    check("t2_count", 32'(count), 32'd0);

    // Fill to full, fifth push held back
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'b00, 32'h10 + 32'(i), 32'h0, 32'h0, 1'b0);
      step();
    end
    set_in(1'b1, 2'b00, 32'h14, 32'h0, 32'h0, 1'b0);
    check("t3_full", 32'(full), 32'd1);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    check("t3_count4", 32'(count), 32'd4);
    step();
    check("t3_held_count", 32'(count), 32'd4);
    check("t3_held_head", out_data, 32'h10);
    pop_one();
    check("t3_pop_no_push", 32'(count), 32'd3);
    check("t3_head2", out_data, 32'h11);
    check("t3_ready_again", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("t3_refull_count", 32'(count), 32'd4);
    check("t3_refull_flag", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_order", out_data, 32'h11 + 32'(i));
      pop_one();
    end
    check("t3_empty", 32'(out_valid), 32'd0);
    check("t3_hi_kept", hi_q, 32'h00000001);
    check("t3_lo_kept", lo_q, 32'h80000000);

    // Sustained streaming with simultaneous push/pop
    set_in(1'b1, 2'b00, 32'd1, 32'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    step();
    check("t4_prime_count", 32'(count), 32'd1);
    for (int k = 2; k <= 10; k++) begin
      in_s = 32'(k);
      check("t4_stream_data", out_data, 32'(k - 1));
      step();
      check("t4_stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    check("t4_last", out_data, 32'd10);
    step();
    out_ready = 1'b0;
    check("t4_drained", 32'(count), 32'd0);

    // DIV with zero result then SUB of all-ones
    set_in(1'b1, 2'b11, 32'h00000055, 32'h0, 32'h0, 1'b0);
    step();
    set_in(1'b1, 2'b01, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    step();
    in_valid = 1'b0;
    check("t5_div_zero", 32'(out_zero), 32'd1);
    check("t5_div_op", 32'(out_op), 32'd3);
    pop_one();
    check("t5_hi_commit", hi_q, 32'h0);
    check("t5_lo_commit", lo_q, 32'h0);
    check("t5_sub_data", out_data, 32'hFFFFFFFF);
    check("t5_sub_zero", 32'(out_zero), 32'd0);
    pop_one();
    check("t5_hi_unchanged", hi_q, 32'h0);
    check("t5_lo_unchanged", lo_q, 32'h0);

    // Mid-operation reset discards queue and clears HI/LO
    set_in(1'b1, 2'b10, 32'h0, 32'h0000000A, 32'h0000000B, 1'b0);
    step();
    in_valid = 1'b0;
    pop_one();
    check("t6_hi_pre", hi_q, 32'h0000000A);
    set_in(1'b1, 2'b00, 32'h21, 32'h0, 32'h0, 1'b0);
    step();
    set_in(1'b1, 2'b10, 32'h0, 32'h00000007, 32'h00000009, 1'b0);
    step();
    set_in(1'b1, 2'b00, 32'h23, 32'h0, 32'h0, 1'b0);
    step();
    in_valid = 1'b0;
    check("t6_count3", 32'(count), 32'd3);
    rst_n = 1'b1;
    #1;
    check("t6_async_count", 32'(count), 32'd0);
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_hi", hi_q, 32'h0);
    check("t6_async_lo", lo_q, 32'h0);
    check("t6_async_ready", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b0;
    set_in(1'b1, 2'b00, 32'h77, 32'h0, 32'h0, 1'b0);
    step();
    in_valid = 1'b0;
    check("t6_resume_count", 32'(count), 32'd1);
    check("t6_resume_data", out_data, 32'h77);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
